// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD arithmetic units.
package bcd_pkg;

    localparam int unsigned DIGITS_DEFAULT = 8;
    localparam int unsigned BCD_RADIX      = 10;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtractor: d = a - b - bin with decimal borrow.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout,
    output logic       invalid
);

    logic [4:0] diff;
    bcd_digit_t adj;

    always_comb begin
        diff    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        // Low nibble of (diff + 10) equals low nibble of diff plus 10 modulo 16.
        adj     = diff[3:0] + 4'(BCD_RADIX);
        bout    = diff[4];
        d       = bout ? adj : diff[3:0];
        invalid = (a > 4'(BCD_RADIX - 1)) || (b > 4'(BCD_RADIX - 1));
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor S = A - B - BIN, LSD first, start/ready in, valid/ack out.
// Optional BCD_SIGN_MAG_EN: negative results are re-complemented to sign/magnitude (NEG=1).
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  BIN,
    input  logic                  START,
    output logic                  READY,
    output logic [4*DIGITS-1:0]   S,
    output logic                  BOUT,
    output logic                  NEG,
    output logic                  ERR,
    output logic                  VALID,
    input  logic                  ACK
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic            bout_q, bout_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;
`ifdef BCD_SIGN_MAG_EN
    logic            neg_q, neg_d;
`endif

    bcd_digit_t      op_a, op_b, dig;
    logic            dig_bout, dig_invalid;
    logic            last_digit;

    // Operand select: CMP reuses the digit subtractor to form 0 - S.
    always_comb begin
`ifdef BCD_SIGN_MAG_EN
        op_a = (state_q == CMP) ? 4'h0 : a_q[3:0];
        op_b = (state_q == CMP) ? s_q[3:0] : b_q[3:0];
`else
        op_a = a_q[3:0];
        op_b = b_q[3:0];
`endif
    end

    bcd_digit_sub u_digit_sub (
        .a       (op_a),
        .b       (op_b),
        .bin     (borrow_q),
        .d       (dig),
        .bout    (dig_bout),
        .invalid (dig_invalid)
    );

    assign last_digit = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        err_d    = err_q;
        valid_d  = valid_q;
`ifdef BCD_SIGN_MAG_EN
        neg_d    = neg_q;
`endif

        case (state_q)
            IDLE: begin
                if (START && ready_q) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = BIN;
                    s_d      = '0;
                    idx_d    = '0;
                    bout_d   = 1'b0;
                    err_d    = 1'b0;
`ifdef BCD_SIGN_MAG_EN
                    neg_d    = 1'b0;
`endif
                    state_d  = SUB;
                end
            end

            SUB: begin
                // New digit enters at the top so S is in place after DIGITS shifts.
                s_d      = W'({dig, s_q} >> 4);
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                borrow_d = dig_bout;
                err_d    = err_q | dig_invalid;
                idx_d    = idx_q + IW'(1);
                if (last_digit) begin
                    bout_d  = dig_bout;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef BCD_SIGN_MAG_EN
                    if (dig_bout) begin
                        borrow_d = 1'b0;
                        neg_d    = 1'b1;
                        state_d  = CMP;
                    end
`endif
                end
            end

`ifdef BCD_SIGN_MAG_EN
            CMP: begin
                s_d      = W'({dig, s_q} >> 4);
                borrow_d = dig_bout;
                idx_d    = idx_q + IW'(1);
                if (last_digit) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                // VALID rises one cycle after entry; ACK only counts once it is up.
                if (valid_q) begin
                    if (ACK) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
`ifdef BCD_SIGN_MAG_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
`ifdef BCD_SIGN_MAG_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign READY = ready_q;
    assign S     = s_q;
    assign BOUT  = bout_q;
    assign ERR   = err_q;
    assign VALID = valid_q;
`ifdef BCD_SIGN_MAG_EN
    assign NEG   = neg_q;
`else
    assign NEG   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor; expectations come from integer decimal arithmetic.
module tb_bcd_serial_subtractor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] A, B, S;
    logic        BIN, START, READY, BOUT, NEG, ERR, VALID, ACK;

    always #5 CLK = ~CLK;

    bcd_serial_subtractor #(.DIGITS(8)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .BIN(BIN), .START(START),
        .READY(READY), .S(S), .BOUT(BOUT), .NEG(NEG), .ERR(ERR),
        .VALID(VALID), .ACK(ACK)
    );

    typedef struct {
        logic [31:0] s;
        logic        bout;
        logic        neg;
        logic        err;
        bit          chk;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic longint bcd2int(input logic [31:0] v);
        longint r = 0;
        for (int k = 7; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v);
        logic [31:0] r;
        longint t = v % 100000000;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [31:0] v);
        bit bad = 1'b0;
        for (int k = 0; k < 8; k++) if (v[4*k +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t   e;
        longint d;
        e.err  = has_bad(a) || has_bad(b);
        e.chk  = !e.err;
        d      = bcd2int(a) - bcd2int(b) - longint'(bin);
        e.bout = (d < 0);
        e.neg  = 1'b0;
        e.lat  = 9;
        if (d < 0) begin
`ifdef BCD_SIGN_MAG_EN
            e.s   = int2bcd(-d);
            e.neg = 1'b1;
            e.lat = 17;
`else
            e.s   = int2bcd(d + 100000000);
`endif
        end else begin
            e.s = int2bcd(d);
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin);
        A = a; B = b; BIN = bin; START = 1'b1;
        sb.push_back(model(a, b, bin));
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        while (VALID !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        to = (VALID !== 1'b1);
    endtask

    task automatic ack_result();
        ACK = 1'b1;
        @(posedge CLK); #1;
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got [6];
        logic [31:0] want[6];
        RST = 1'b1; A = '0; B = '0; BIN = 1'b0; START = 1'b0; ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        got  = '{32'(READY), 32'(VALID), S, 32'(BOUT), 32'(ERR), 32'(NEG)};
        want = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL reset_out%0d got %h want %h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_table(input string name, input logic [31:0] ta[4],
                              input logic [31:0] tb[4], input logic tbin[4]);
        exp_t e; int lat; bit to;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], tbin[i]);
            wait_valid(lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to) begin n_fail++; $display("FAIL %s_timeout op%0d VALID never rose", name, i); end
            n_checks++;
            if (S !== e.s) begin n_fail++; $display("FAIL %s_s op%0d got %h want %h", name, i, S, e.s); end
            n_checks++;
            if (BOUT !== e.bout) begin n_fail++; $display("FAIL %s_bout op%0d got %b want %b", name, i, BOUT, e.bout); end
            n_checks++;
            if (NEG !== e.neg) begin n_fail++; $display("FAIL %s_neg op%0d got %b want %b", name, i, NEG, e.neg); end
            n_checks++;
            if (ERR !== e.err) begin n_fail++; $display("FAIL %s_err op%0d got %b want %b", name, i, ERR, e.err); end
            n_checks++;
            if (lat != e.lat) begin n_fail++; $display("FAIL %s_latency op%0d got %0d want %0d", name, i, lat, e.lat); end
            ack_result();
            n_checks++;
            if (READY !== 1'b1 || VALID !== 1'b0) begin
                n_fail++; $display("FAIL %s_ack op%0d got ready=%b valid=%b want 1/0", name, i, READY, VALID);
            end
        end
    endtask

    task automatic test_basic();
        test_table("basic",
                   '{32'h00000100, 32'h98765432, 32'h99999999, 32'h00000050},
                   '{32'h00000001, 32'h12345678, 32'h99999999, 32'h00000049},
                   '{1'b0, 1'b1, 1'b0, 1'b1});
        // Independent anchor for the first table entry.
        n_checks++;
        if (int2bcd(100 - 1) !== 32'h00000099) begin n_fail++; $display("FAIL basic_anchor got %h want 00000099", int2bcd(99)); end
    endtask

    task automatic test_negative();
        test_table("negative",
                   '{32'h12345678, 32'h00000000, 32'h00000000, 32'h00001000},
                   '{32'h12345678, 32'h00000001, 32'h99999999, 32'h00001001},
                   '{1'b1, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_err();
        logic [31:0] ta[3] = '{32'h0000000A, 32'h00000005, 32'h00000005};
        logic [31:0] tb[3] = '{32'h00000003, 32'h00000003, 32'h000000F0};
        exp_t e; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], 1'b0);
            wait_valid(lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to) begin n_fail++; $display("FAIL err_timeout op%0d VALID never rose", i); end
            n_checks++;
            if (ERR !== e.err) begin n_fail++; $display("FAIL err_flag op%0d got %b want %b", i, ERR, e.err); end
            if (e.chk) begin
                n_checks++;
                if (S !== e.s) begin n_fail++; $display("FAIL err_s op%0d got %h want %h", i, S, e.s); end
            end
            ack_result();
        end
    endtask

    task automatic test_rst_mid();
        exp_t e; int lat; bit to; bit saw_valid;
        issue(32'h12345678, 32'h00000001, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        void'(sb.pop_front());
        n_checks++;
        if (READY !== 1'b1 || VALID !== 1'b0 || S !== 32'h0 || ERR !== 1'b0 || BOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state got ready=%b valid=%b s=%h err=%b bout=%b want 1/0/0/0/0",
                     READY, VALID, S, ERR, BOUT);
        end
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (VALID !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin n_fail++; $display("FAIL rst_mid_partial got valid=1 want 0 after abort"); end
        issue(32'h00000050, 32'h00000025, 1'b0);
        wait_valid(lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to || S !== e.s || lat != e.lat) begin
            n_fail++; $display("FAIL rst_mid_next got s=%h lat=%0d want s=%h lat=%0d", S, lat, e.s, e.lat);
        end
        ack_result();
    endtask

    task automatic test_ack_hold();
        exp_t e; int lat; bit to;
        issue(32'h00004321, 32'h00001234, 1'b0);
        wait_valid(lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to || S !== e.s) begin n_fail++; $display("FAIL hold_first got s=%h want %h", S, e.s); end
        for (int i = 0; i < 5; i++) begin
            START = 1'b1; A = 32'h99999999; B = 32'h00000000;
            @(posedge CLK); #1;
            n_checks++;
            if (VALID !== 1'b1 || S !== e.s || READY !== 1'b0 || BOUT !== e.bout) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got valid=%b s=%h ready=%b want 1/%h/0", i, VALID, S, READY, e.s);
            end
        end
        START = 1'b0;
        ack_result();
        n_checks++;
        if (READY !== 1'b1 || VALID !== 1'b0) begin
            n_fail++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", READY, VALID);
        end
    endtask

    task automatic test_ack_idle();
        ACK = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        ACK = 1'b0;
        n_checks++;
        if (READY !== 1'b1 || VALID !== 1'b0) begin
            n_fail++; $display("FAIL ack_idle got ready=%b valid=%b want 1/0", READY, VALID);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; bit to;
        for (int i = 0; i < 8; i++) begin
            issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
            wait_valid(lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to || S !== e.s || BOUT !== e.bout || NEG !== e.neg || ERR !== 1'b0 || lat != e.lat) begin
                n_fail++;
                $display("FAIL b2b op%0d got s=%h bout=%b neg=%b err=%b lat=%0d want s=%h bout=%b neg=%b err=0 lat=%0d",
                         i, S, BOUT, NEG, ERR, lat, e.s, e.bout, e.neg, e.lat);
            end
            ack_result();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_err();
        test_rst_mid();
        test_ack_hold();
        test_ack_idle();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
